// File: rtl/register_harness_pkg.sv
// register_harness_pkg: shared FSM state type and default word width for the serial word loader
package register_harness_pkg;

    localparam int DEFAULT_BITWIDTH = 16;

    typedef enum logic {
        SHIFT,
        FULL
    } state_t;

endpackage

// File: rtl/serial_word_loader.sv
// serial_word_loader: assembles LSB-first serial bits into BITWIDTH-bit words for a downstream register harness
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   s_data      serial data bit, LSB of the word first
//   s_valid     s_data is valid this cycle
//   s_ready     loader accepts a serial bit this cycle (low while a complete word waits in the shift register)
//   m_data      assembled output word
//   m_valid     m_data holds an unconsumed word
//   m_ready     downstream takes m_data this cycle
//   clr_overrun synchronous clear of the overrun flag
//   overrun     sticky: a bit was offered while s_ready was low
//   bit_count   bits currently held in the shift register
module serial_word_loader
    import register_harness_pkg::*;
#(
    parameter int BITWIDTH = DEFAULT_BITWIDTH
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            s_data,
    input  logic                            s_valid,
    output logic                            s_ready,
    output logic [BITWIDTH-1:0]             m_data,
    output logic                            m_valid,
    input  logic                            m_ready,
    input  logic                            clr_overrun,
    output logic                            overrun,
    output logic [$clog2(BITWIDTH+1)-1:0]   bit_count
);

    localparam int CW = $clog2(BITWIDTH + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(BITWIDTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(BITWIDTH);

    state_t              state;
    logic [BITWIDTH-1:0] shift_reg;
    logic [BITWIDTH-1:0] word;
    logic                accept;

    assign s_ready = state == SHIFT;
    assign accept  = s_valid && s_ready;
    // Shift register is cleared whenever a word leaves it, so OR-ing the new bit in is enough
    assign word    = shift_reg | (BITWIDTH'(s_data) << bit_count);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= SHIFT;
            shift_reg <= '0;
            bit_count <= '0;
            m_data    <= '0;
            m_valid   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (s_valid && !s_ready)
                overrun <= 1'b1;
            else if (clr_overrun)
                overrun <= 1'b0;
            // Consumption clears m_valid unless a load below refills it at the same edge
            if (m_ready)
                m_valid <= 1'b0;
            if (state == FULL) begin
                if (m_ready) begin
                    m_data    <= shift_reg;
                    m_valid   <= 1'b1;
                    shift_reg <= '0;
                    bit_count <= '0;
                    state     <= SHIFT;
                end
            end else if (accept) begin
                if (bit_count != LAST_IDX) begin
                    shift_reg <= word;
                    bit_count <= bit_count + 1'b1;
                end else if (!m_valid || m_ready) begin
                    m_data    <= word;
                    m_valid   <= 1'b1;
                    shift_reg <= '0;
                    bit_count <= '0;
                end else begin
                    shift_reg <= word;
                    bit_count <= FULL_CNT;
                    state     <= FULL;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_word_loader.sv
// tb_serial_word_loader: scoreboard bench for serial_word_loader with an occupancy-based reference model
module tb_serial_word_loader;

    localparam int BW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          s_data = 1'b0, s_valid = 1'b0, m_ready = 1'b0, clr_overrun = 1'b0;
    logic          s_ready, m_valid, overrun;
    logic [BW-1:0] m_data;
    logic [4:0]    bit_count;

    logic          s4_data = 1'b0, s4_valid = 1'b0, m4_ready = 1'b0, clr4 = 1'b0;
    logic          s4_ready, m4_valid, ovr4;
    logic [3:0]    m4_data;
    logic [2:0]    bc4;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    serial_word_loader #(.BITWIDTH(BW)) dut (
        .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .clr_overrun(clr_overrun),
        .overrun(overrun), .bit_count(bit_count)
    );

    serial_word_loader #(.BITWIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .s_data(s4_data), .s_valid(s4_valid), .s_ready(s4_ready),
        .m_data(m4_data), .m_valid(m4_valid), .m_ready(m4_ready), .clr_overrun(clr4),
        .overrun(ovr4), .bit_count(bc4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: words are whole BW-bit groups of accepted bits; the loader
    // can hold at most two finished words (output register + full shift register).
    logic [BW-1:0] exp_q[$];
    int            pend = 0;
    int            part = 0;
    logic [BW-1:0] pword = '0;
    logic          movr = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_q.delete();
            pend  = 0;
            part  = 0;
            pword = '0;
            movr  = 1'b0;
        end else begin
            bit acc, done, cons;
            acc  = s_valid && pend < 2;
            cons = m_ready && pend > 0;
            done = 1'b0;
            if (s_valid && pend >= 2)
                movr = 1'b1;
            else if (clr_overrun)
                movr = 1'b0;
            if (acc) begin
                pword[part] = s_data;
                part++;
                if (part == BW) begin
                    exp_q.push_back(pword);
                    part  = 0;
                    pword = '0;
                    done  = 1'b1;
                end
            end
            pend = pend - int'(cons) + int'(done);
        end
    end

    // Monitor: status every cycle, data compared against the queue whenever a word is handed off
    always @(negedge clk) begin
        if (!reset) begin
            check("rst_m_data", 64'(m_data), 64'(0));
        end else begin
            check("m_valid", 64'(m_valid), 64'(pend > 0));
            check("s_ready", 64'(s_ready), 64'(pend < 2));
            check("bit_count", 64'(bit_count), 64'(pend == 2 ? BW : part));
            check("overrun", 64'(overrun), 64'(movr));
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 64'(m_data), 64'hDEAD_0000_0000_0000);
                end else begin
                    logic [BW-1:0] e;
                    e = exp_q.pop_front();
                    check("m_data", 64'(m_data), 64'(e));
                end
            end
        end
    end

    logic [3:0] cap_d[$];
    int         cap_t[$];
    always @(negedge clk) begin
        if (reset && m4_valid) begin
            cap_d.push_back(m4_data);
            cap_t.push_back(cyc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [BW-1:0] w);
        for (int i = 0; i < BW; i++) begin
            s_valid = 1'b1;
            s_data  = w[i];
            step();
        end
        s_valid = 1'b0;
    endtask

    initial begin
        logic [BW-1:0] w;
        logic [7:0]    pair;
        repeat (3) step();
        check("rst_s_ready", 64'(s_ready), 64'(1));
        check("rst_bit_count", 64'(bit_count), 64'(0));
        reset = 1'b1;
        step();

        m_ready = 1'b1;
        send_word(16'hA5C3);
        check("a5c3_data", 64'(m_data), 64'hA5C3);
        check("a5c3_valid", 64'(m_valid), 64'(1));
        step();
        check("a5c3_one_cycle", 64'(m_valid), 64'(0));
        check("a5c3_overrun", 64'(overrun), 64'(0));

        m_ready = 1'b0;
        send_word(16'h1234);
        send_word(16'hBEEF);
        check("full_s_ready", 64'(s_ready), 64'(0));
        check("full_m_data", 64'(m_data), 64'h1234);
        check("full_bit_count", 64'(bit_count), 64'(16));
        s_valid = 1'b1;
        repeat (3) step();
        s_valid = 1'b0;
        check("drop_overrun", 64'(overrun), 64'(1));
        check("drop_bit_count", 64'(bit_count), 64'(16));
        clr_overrun = 1'b1;
        step();
        clr_overrun = 1'b0;
        check("clr_overrun", 64'(overrun), 64'(0));
        m_ready = 1'b1;
        step();
        check("beef_data", 64'(m_data), 64'hBEEF);
        check("beef_s_ready", 64'(s_ready), 64'(1));
        step();
        m_ready = 1'b0;

        send_word(16'h5A5A);
        w = 16'h0F0F;
        for (int i = 0; i < BW; i++) begin
            m_ready = (i == BW - 1);
            s_valid = 1'b1;
            s_data  = w[i];
            step();
        end
        s_valid = 1'b0;
        check("swap_valid", 64'(m_valid), 64'(1));
        check("swap_data", 64'(m_data), 64'h0F0F);
        check("swap_s_ready", 64'(s_ready), 64'(1));
        step();
        m_ready = 1'b0;

        for (int i = 0; i < 7; i++) begin
            s_valid = 1'b1;
            s_data  = 1'($urandom);
            step();
        end
        s_valid = 1'b0;
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        m_ready = 1'b1;
        send_word(16'h00FF);
        check("stale_data", 64'(m_data), 64'h00FF);
        check("stale_valid", 64'(m_valid), 64'(1));
        step();
        m_ready = 1'b0;

        pair = 8'h69;
        m4_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s4_valid = 1'b1;
            s4_data  = pair[i];
            step();
        end
        s4_valid = 1'b0;
        repeat (3) step();
        check("w4_count", 64'(cap_d.size()), 64'(2));
        if (cap_d.size() == 2) begin
            check("w4_first", 64'(cap_d[0]), 64'h9);
            check("w4_second", 64'(cap_d[1]), 64'h6);
            check("w4_spacing", 64'(cap_t[1] - cap_t[0]), 64'(4));
        end

        for (int n = 0; n < 3000; n++) begin
            s_valid     = $urandom_range(0, 3) != 0;
            s_data      = 1'($urandom);
            m_ready     = $urandom_range(0, 2) == 0;
            clr_overrun = $urandom_range(0, 15) == 0;
            reset       = $urandom_range(0, 499) != 0;
            step();
            reset = 1'b1;
        end

        s_valid = 1'b0;
        clr_overrun = 1'b0;
        m_ready = 1'b1;
        repeat (5) step();
        check("drain_empty", 64'(exp_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
